// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters.
// Optional start-up zeroing of the whole RAM is compiled in with `define RAM_ARB_CLEAR_EN.
module ram_arbiter #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset_n,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic [AW-1:0] ram_addr,
  output logic          ram_wEn,
  output logic [DW-1:0] ram_wDat,
  output logic          ram_rEn,
  input  logic [DW-1:0] ram_rDat,

  output logic          busy
);

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_CLEAR      = 2'd1,
    ST_RUN        = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;         // requester granted most recently
  logic   m0_rvalid_q, m0_rvalid_d;
  logic   m1_rvalid_q, m1_rvalid_d;

`ifdef RAM_ARB_CLEAR_EN
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

  // NOTE: next-state logic assigns every output a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    ram_addr    = '0;
    ram_wDat    = '0;
    ram_wEn     = 1'b0;
    ram_rEn     = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif

    case (state_q)
      ST_RESET_HOLD: begin
`ifdef RAM_ARB_CLEAR_EN
        state_d = ST_CLEAR;
`else
        state_d = ST_RUN;
`endif
      end

`ifdef RAM_ARB_CLEAR_EN
      ST_CLEAR: begin
        ram_wEn   = 1'b1;
        ram_addr  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
`endif

      ST_RUN: begin
        // Under contention the requester that did not win last time goes first.
        if (m0_req && (!m1_req || last_q)) begin
          m0_gnt = 1'b1;
        end else if (m1_req) begin
          m1_gnt = 1'b1;
        end

        if (m0_gnt) begin
          last_d   = 1'b0;
          ram_addr = m0_addr;
          ram_wEn  = m0_we;
          ram_rEn  = !m0_we;
          ram_wDat = m0_we ? m0_wdata : '0;
        end else if (m1_gnt) begin
          last_d   = 1'b1;
          ram_addr = m1_addr;
          ram_wEn  = m1_we;
          ram_rEn  = !m1_we;
          ram_wDat = m1_we ? m1_wdata : '0;
        end
      end

      default: begin
        state_d = ST_RESET_HOLD;
      end
    endcase
  end

  assign m0_rvalid_d = m0_gnt && !m0_we;
  assign m1_rvalid_d = m1_gnt && !m1_we;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET_HOLD;
      last_q      <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

`ifdef RAM_ARB_CLEAR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end
`endif

  // Read data comes straight from the RAM; rvalid tells each requester whose it is.
  assign m0_rdata  = ram_rDat;
  assign m1_rdata  = ram_rDat;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign busy      = (state_q != ST_RUN);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, shadow-memory model and
// round-robin rule checked against randomized and directed traffic.
module tb_ram_arbiter;

`ifdef RAM_ARB_CLEAR_EN
  localparam int EXP_BUSY = 513;
`else
  localparam int EXP_BUSY = 1;
`endif

  logic        clock;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [8:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [8:0]  ram_addr;
  logic        ram_wEn, ram_rEn;
  logic [31:0] ram_wDat, ram_rDat;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.AW(9), .DW(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .ram_addr (ram_addr),
    .ram_wEn  (ram_wEn),
    .ram_wDat (ram_wDat),
    .ram_rEn  (ram_rEn),
    .ram_rDat (ram_rDat),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural single-port synchronous RAM, with a back door for preloading.
  bit   [31:0] ram_mem [512];
  logic [31:0] ram_rdat_q;
  logic        pre_we;
  logic [8:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clock) begin
    if (pre_we) ram_mem[pre_addr] <= pre_data;
    else if (ram_wEn) ram_mem[ram_addr] <= ram_wDat;
    if (ram_rEn) ram_rdat_q <= ram_mem[ram_addr];
  end
  assign ram_rDat = ram_rdat_q;

  // Reference model: expected memory contents, round-robin pointer, pending read.
  bit   [31:0] ref_mem [512];
  int          m_last = 1;
  int          pend = -1;
  logic [31:0] pend_data = '0;

  task automatic model_reset();
    m_last = 1;
    pend   = -1;
`ifdef RAM_ARB_CLEAR_EN
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
`endif
  endtask

  // One RUN cycle: drive, compare DUT against the model at negedge, advance model.
  task automatic step(input logic r0, input logic w0, input logic [8:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [8:0] a1, input logic [31:0] d1,
                      output logic [1:0] gnt_seen);
    int          winner;
    logic        exp_we;
    logic [8:0]  exp_addr;
    logic [31:0] exp_wdat;
    logic [4:0]  exp_ctrl, act_ctrl;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    if (r0 && r1)  winner = (m_last == 0) ? 1 : 0;
    else if (r0)   winner = 0;
    else if (r1)   winner = 1;
    else           winner = -1;
    exp_we   = (winner == 0) ? w0 : (winner == 1) ? w1 : 1'b0;
    exp_addr = (winner == 0) ? a0 : (winner == 1) ? a1 : 9'd0;
    exp_wdat = (winner < 0) ? 32'd0 : (winner == 0) ? d0 : d1;
    @(negedge clock);
    gnt_seen = {m0_gnt, m1_gnt};
    exp_ctrl = {winner == 0, winner == 1, (winner >= 0) && exp_we, (winner >= 0) && !exp_we, 1'b0};
    act_ctrl = {m0_gnt, m1_gnt, ram_wEn, ram_rEn, busy};
    checks++;
    if (act_ctrl !== exp_ctrl) begin
      errors++;
      $display("FAIL ctrl {gnt0,gnt1,wEn,rEn,busy} got %b want %b at %0t", act_ctrl, exp_ctrl, $time);
    end
    checks++;
    if (ram_addr !== exp_addr) begin
      errors++;
      $display("FAIL ram_addr got %h want %h at %0t", ram_addr, exp_addr, $time);
    end
    if (winner < 0 || exp_we) begin
      checks++;
      if (ram_wDat !== exp_wdat) begin
        errors++;
        $display("FAIL ram_wDat got %h want %h at %0t", ram_wDat, exp_wdat, $time);
      end
    end
    checks++;
    if ({m0_rvalid, m1_rvalid} !== {pend == 0, pend == 1}) begin
      errors++;
      $display("FAIL rvalid {m0,m1} got %b want %b at %0t", {m0_rvalid, m1_rvalid}, {pend == 0, pend == 1}, $time);
    end
    if (pend >= 0) begin
      checks++;
      if (m0_rdata !== pend_data || m1_rdata !== pend_data) begin
        errors++;
        $display("FAIL rdata got %h/%h want %h at %0t", m0_rdata, m1_rdata, pend_data, $time);
      end
    end
    pend = -1;
    if (winner >= 0) begin
      m_last = winner;
      if (exp_we) ref_mem[exp_addr] = exp_wdat;
      else begin
        pend      = winner;
        pend_data = ref_mem[exp_addr];
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  // Counts cycles until busy falls (bounded) and any grants seen while busy.
  task automatic wait_ready(output int n, output int bad_gnt);
    n = 0;
    bad_gnt = 0;
    while (n < 2000) begin
      @(posedge clock); #1;
      n++;
      if (!busy) break;
      if (m0_gnt || m1_gnt || ram_rEn) bad_gnt++;
    end
  endtask

  task automatic test_reset();
    int n, bad;
    idle_inputs();
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 9'h033; m1_addr = 9'h044; m0_we = 1'b1;
    m0_wdata = 32'hA5A5_5A5A;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({m0_gnt, m1_gnt, ram_wEn, ram_rEn, busy} !== 5'b00001 || ram_addr !== 9'd0 || ram_wDat !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs got gnt=%b%b wEn=%b rEn=%b busy=%b addr=%h wDat=%h want 0 0 0 0 1 0 0",
                 m0_gnt, m1_gnt, ram_wEn, ram_rEn, busy, ram_addr, ram_wDat);
      end
      checks++;
      if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL reset_rvalid got %b want 00", {m0_rvalid, m1_rvalid});
      end
      @(posedge clock);
    end
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b1;
    wait_ready(n, bad);
    checks++;
    if (n !== EXP_BUSY || bad !== 0) begin
      errors++;
      $display("FAIL busy_after_reset got %0d cycles (%0d grants) want %0d cycles (0 grants)", n, bad, EXP_BUSY);
    end
    model_reset();
  endtask

  task automatic test_single_read();
    logic [1:0] g;
    step(1'b1, 1'b1, 9'h005, 32'hDEAD_BEEF, 1'b0, 1'b0, 9'h0, 32'h0, g);
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h005, 32'h0, g);
    checks++;
    if (g !== 2'b01) begin
      errors++;
      $display("FAIL single_read_gnt got %b want 01", g);
    end
    checks++;
    if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_read_data got v0=%b v1=%b data=%h want v0=0 v1=1 data=deadbeef",
               m0_rvalid, m1_rvalid, m1_rdata);
    end
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, g);
  endtask

  task automatic test_contention();
    logic [1:0] g;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), $urandom,
           1'b1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), $urandom, g);
      checks++;
      if (g !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_%0d got %b want %b", i, g, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, g);
  endtask

  task automatic test_back_to_back();
    logic [1:0] g;
    step(1'b1, 1'b1, 9'h1FF, 32'h1234_5678, 1'b0, 1'b0, 9'h0, 32'h0, g);
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h1FF, 32'h0, g);
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL read_after_write got v=%b data=%h want v=1 data=12345678", m1_rvalid, m1_rdata);
    end
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, g);
  endtask

  task automatic test_random();
    logic [1:0] g;
    logic [8:0] a0, a1;
    for (int i = 0; i < 300; i++) begin
      a0 = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a0, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a1, $urandom, g);
    end
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, g);
  endtask

`ifdef RAM_ARB_CLEAR_EN
  task automatic test_clear();
    int n, bad;
    logic [1:0] g;
    reset_n = 1'b0;
    pre_we = 1'b1; pre_addr = 9'h00A; pre_data = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    pre_we = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h00A;
    @(negedge clock);
    reset_n = 1'b1;
    wait_ready(n, bad);
    checks++;
    if (n !== 513 || bad !== 0) begin
      errors++;
      $display("FAIL clear_busy got %0d cycles (%0d grants) want 513 cycles (0 grants)", n, bad);
    end
    model_reset();
    step(1'b1, 1'b0, 9'h00A, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, g);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL clear_read got v=%b data=%h want v=1 data=00000000", m0_rvalid, m0_rdata);
    end
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, g);
  endtask
`endif

  task automatic test_reset_mid();
    int n, bad;
    logic [1:0] g;
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b1, 9'h007, 32'hCAFE_0007, g);
    step(1'b1, 1'b0, 9'h007, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, g);
    m0_req = 1'b1; m1_req = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, ram_wEn, ram_rEn, busy} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_mid got rv=%b%b gnt=%b%b wEn=%b rEn=%b busy=%b want rv=00 gnt=00 wEn=0 rEn=0 busy=1",
               m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, ram_wEn, ram_rEn, busy);
    end
    @(negedge clock);
    reset_n = 1'b1;
    wait_ready(n, bad);
    checks++;
    if (n !== EXP_BUSY || bad !== 0) begin
      errors++;
      $display("FAIL reset_mid_busy got %0d cycles (%0d grants) want %0d cycles (0 grants)", n, bad, EXP_BUSY);
    end
    model_reset();
    step(1'b1, 1'b0, 9'h007, 32'h0, 1'b1, 1'b0, 9'h008, 32'h0, g);
    checks++;
    if (g !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_first_contest got %b want 10", g);
    end
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, g);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_random();
`ifdef RAM_ARB_CLEAR_EN
    test_clear();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
